// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and decode helpers for the ripple and bit-serial ALUs.
// Latency: none, constants and pure functions only.
// Backpressure: not applicable.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Two's-complement subtract ops: B is inverted and carry-in starts at 1.
   function automatic logic is_sub(input logic [2:0] op);
      return (op == ALU_SUB) || (op == ALU_SLT);
   endfunction

   // Ops whose final carry is meaningful to the consumer.
   function automatic logic is_arith(input logic [2:0] op);
      return (op == ALU_ADD) || is_sub(op);
   endfunction

endpackage

// File: rtl/bit_serial_alu_seq_if.sv
// Operand/result handshake bundle for the bit-serial ALU.
// Latency: none, wires only.
// Backpressure: valid/ready on the operand side and on the result side.
interface bit_serial_alu_seq_if #(parameter int WIDTH = 32);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry_out;

   modport master (
      output flush, in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry_out
   );

   modport slave (
      input  flush, in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry_out
   );

endinterface

// File: rtl/bitALU.sv
// One-bit ALU slice: AND, OR, and full-adder add/subtract on a single bit position.
// Latency: purely combinational.
// Backpressure: none, the caller sequences it.
module bitALU
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       out,
   output logic       cout
);

   logic b_eff;

   // Subtract ops add the inverted B bit; illegal ops produce 0 with no carry.
   always_comb begin
      b_eff = b ^ is_sub(op);
      out   = 1'b0;
      cout  = 1'b0;
      case (op)
         ALU_AND: out = a & b;
         ALU_OR:  out = a | b;
         ALU_ADD, ALU_SUB, ALU_SLT: begin
            out  = a ^ b_eff ^ cin;
            cout = (a & b_eff) | (cin & (a ^ b_eff));
         end
         default: begin
            out  = 1'b0;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU: one WIDTH-bit op through a single 1-bit slice, LSB first, carry held in a flop.
// Latency: out_valid rises WIDTH cycles after accept; one op per WIDTH+2 cycles at best.
// Backpressure: DONE holds until out_ready; in_ready is high only in IDLE.
module bit_serial_alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic                clk,
   input logic                rst_n,
   bit_serial_alu_seq_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [2:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic             slice_out, slice_cout;
   logic [WIDTH-1:0] res_fmt;

   // The slice's carry-in comes straight from the carry flop.
   bitALU u_slice (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .out  (slice_out),
      .cout (slice_cout)
   );

   // Next-state: flush wins over everything, otherwise IDLE -> RUN -> DONE -> IDLE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      op_d     = op_q;
      carry_d  = carry_q;
      if (bus.flush) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         a_sh_d   = '0;
         b_sh_d   = '0;
         res_sh_d = '0;
         op_d     = '0;
         carry_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_sh_d   = bus.a;
                  b_sh_d   = bus.b;
                  op_d     = bus.op;
                  res_sh_d = '0;
                  cnt_d    = '0;
                  carry_d  = is_sub(bus.op);
                  state_d  = S_RUN;
               end
            end
            S_RUN: begin
               a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
               b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
               res_sh_d = {slice_out, res_sh_q[WIDTH-1:1]};
               carry_d  = slice_cout;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
      end
   end

   // Outputs are forced to 0 except in DONE; SLT reduces to the sign bit of A-B.
   always_comb begin
      res_fmt       = (op_q == ALU_SLT) ? {{(WIDTH-1){1'b0}}, res_sh_q[WIDTH-1]} : res_sh_q;
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_DONE);
      bus.result    = '0;
      bus.zero      = 1'b0;
      bus.carry_out = 1'b0;
      if (state_q == S_DONE) begin
         bus.result    = res_fmt;
         bus.zero      = (res_fmt == '0);
         bus.carry_out = is_arith(op_q) & carry_q;
      end
   end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq: directed vectors plus randomized traffic.
// Latency: expects out_valid exactly WIDTH cycles after accept.
// Backpressure: exercises out_ready stalls, flush and mid-operation reset.
module tb_bit_serial_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bit_serial_alu_seq_if #(.WIDTH(W)) bus ();

   bit_serial_alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Reference arithmetic for one whole operation.
   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         c;
   } exp_t;

   function automatic exp_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
      logic [W:0] s;
      exp_t e;
      e = '0;
      s = '0;
      case (o)
         ALU_AND: e.res = x & y;
         ALU_OR:  e.res = x | y;
         ALU_ADD: begin
            s = {1'b0, x} + {1'b0, y};
            e.res = s[W-1:0];
            e.c = s[W];
         end
         ALU_SUB: begin
            s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            e.res = s[W-1:0];
            e.c = s[W];
         end
         ALU_SLT: begin
            s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            e.res = {{(W-1){1'b0}}, s[W-1]};
            e.c = s[W];
         end
         default: e.res = '0;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Transaction-level model: busy flag plus cycles remaining until the result shows.
   logic m_busy;
   int   m_wait;
   exp_t m_exp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_wait <= 0;
         m_exp  <= '0;
      end else if (bus.flush) begin
         m_busy <= 1'b0;
         m_wait <= 0;
      end else if (!m_busy) begin
         if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_wait <= W;
            m_exp  <= ref_op(bus.a, bus.b, bus.op);
         end
      end else if (m_wait != 0) begin
         m_wait <= m_wait - 1;
      end else if (bus.out_ready) begin
         m_busy <= 1'b0;
      end
   end

   // Every cycle out of reset: handshake signals match the model, and results when presented.
   always @(negedge clk) begin
      if (rst_n) begin
         chk1("in_ready", bus.in_ready, !m_busy);
         chk1("out_valid", bus.out_valid, m_busy && (m_wait == 0));
         if (m_busy && (m_wait == 0) && bus.out_valid) begin
            chkw("model result", bus.result, m_exp.res);
            chk1("model zero", bus.zero, m_exp.z);
            chk1("model carry_out", bus.carry_out, m_exp.c);
         end
      end
   end

   // Drive one op from IDLE, check latency and literal outputs, then consume it.
   task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] o, input logic [W-1:0] er, input logic ez, input logic ec);
      int n;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = x;
      bus.b = y;
      bus.op = o;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chkw({nm, " latency"}, W'(n), W'(W));
      chkw({nm, " result"}, bus.result, er);
      chk1({nm, " zero"}, bus.zero, ez);
      chk1({nm, " carry_out"}, bus.carry_out, ec);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      int seen;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op = '0;
      bus.out_ready = 1'b0;

      // Reset state.
      #3;
      chk1("reset out_valid", bus.out_valid, 1'b0);
      chkw("reset result", bus.result, '0);
      chk1("reset zero", bus.zero, 1'b0);
      chk1("reset carry_out", bus.carry_out, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk1("post-reset in_ready", bus.in_ready, 1'b1);

      // Directed vectors.
      run_op("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h8000_0000, 1'b0, 1'b0);
      run_op("sub eq", 32'd5, 32'd5, ALU_SUB, 32'h0, 1'b1, 1'b1);
      run_op("sub neg", 32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("slt 3,7", 32'd3, 32'd7, ALU_SLT, 32'd1, 1'b0, 1'b0);
      run_op("slt 7,3", 32'd7, 32'd3, ALU_SLT, 32'd0, 1'b1, 1'b1);
      run_op("slt -1,1", 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1, 1'b0, 1'b1);
      run_op("slt 1,-1", 32'd1, 32'hFFFF_FFFF, ALU_SLT, 32'd0, 1'b1, 1'b0);
      run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 32'hF000_F000, 1'b0, 1'b0);
      run_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR, 32'hFFF0_FFF0, 1'b0, 1'b0);
      run_op("illegal", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'h0, 1'b1, 1'b0);

      // Backpressure: new operands waiting while the result is stalled.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'd100;
      bus.b = 32'd23;
      bus.op = ALU_ADD;
      @(negedge clk);
      bus.a = 32'd50;
      bus.b = 32'd8;
      bus.op = ALU_SUB;
      wait_valid(n);
      chkw("bp latency", W'(n), W'(W));
      for (int i = 0; i < 5; i++) begin
         chkw("bp stable result", bus.result, 32'd123);
         chk1("bp in_ready low", bus.in_ready, 1'b0);
         chk1("bp out_valid held", bus.out_valid, 1'b1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk1("bp idle out_valid", bus.out_valid, 1'b0);
      chk1("bp idle in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk1("bp second accepted", bus.in_ready, 1'b0);
      wait_valid(n);
      chkw("bp second latency", W'(n), W'(W));
      chkw("bp second result", bus.result, 32'd42);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Reset in the middle of RUN.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'd1;
      bus.b = 32'd2;
      bus.op = ALU_ADD;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk1("arst out_valid", bus.out_valid, 1'b0);
      chkw("arst result", bus.result, '0);
      chk1("arst zero", bus.zero, 1'b0);
      chk1("arst carry_out", bus.carry_out, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk1("arst release in_ready", bus.in_ready, 1'b1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chkw("arst no partial result", W'(seen), '0);

      // Flush while DONE discards the result.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'd9;
      bus.b = 32'd4;
      bus.op = ALU_OR;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(n);
      chk1("flush pre out_valid", bus.out_valid, 1'b1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk1("flush out_valid drop", bus.out_valid, 1'b0);
      chk1("flush in_ready", bus.in_ready, 1'b1);

      // Flush and in_valid together in IDLE: nothing accepted.
      bus.flush = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      chk1("flush beats accept", bus.in_ready, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         bus.in_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: bus.a = 32'hFFFF_FFFF;
            1: bus.a = 32'h8000_0000;
            default: bus.a = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0: bus.b = bus.a;
            1: bus.b = 32'h0000_0001;
            default: bus.b = $urandom;
         endcase
         bus.op = 3'($urandom_range(0, 7));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
